vector_stream_out: RTL and testbench

//  Drains a full N-element result vector (e.g. c[] from vector_add) and emits it one element
//  per beat on a valid/ready stream, index 0 first. Sits between the parallel vector datapath
//  and any serial consumer (FIFO, DMA writer, debug port). Single-entry buffer: one vector in flight.

---
 rtl/vec_pkg.sv | 21 ++
 rtl/vector_stream_out.sv | 173 +++++++++++++++++
 tb/tb_vector_stream_out.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// -----------------------------------------------------------------------------
// vec_pkg
//   Shared definitions for the vector streaming blocks.
//   VEC_N       default number of vector elements
//   VEC_W       default element width in bits
//   vec_elem_t  one vector element at the default width
//   vec_stream_state_t  state of the drain FSM in vector_stream_out
// -----------------------------------------------------------------------------
package vec_pkg;

  localparam int VEC_N = 16;
  localparam int VEC_W = 32;

  typedef logic [VEC_W-1:0] vec_elem_t;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } vec_stream_state_t;

endpackage : vec_pkg

// File: rtl/vector_stream_out.sv
// -----------------------------------------------------------------------------
// vector_stream_out
//   Captures a full N-element vector in one cycle and emits it one element per
//   beat on a valid/ready stream, index 0 first. Single-entry buffer: a new
//   vector is accepted only once the previous one has fully drained.
//
// Parameters
//   N  number of elements (>= 2)
//   W  element width in bits
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-high reset
//   load_valid      load_data holds a vector to capture
//   load_ready      block is idle and can accept a vector
//   load_data       unpacked array [N] of W-bit elements
//   out_valid       out_data / out_index / out_last are valid
//   out_ready       consumer accepts the current beat
//   out_data        current element
//   out_index       index of the current element
//   out_last        current beat is element N-1
//   busy            a vector is captured and not yet fully drained
//   checksum_out    (VEC_STREAM_CHECKSUM_EN only) wrap-around sum of the last
//                   fully drained vector
//   checksum_valid  (VEC_STREAM_CHECKSUM_EN only) one-cycle pulse, the cycle
//                   after the last beat of a vector
//
// Configuration
//   Define VEC_STREAM_CHECKSUM_EN to add the checksum ports and accumulator.
// -----------------------------------------------------------------------------
module vector_stream_out
  import vec_pkg::*;
#(
  parameter int N = VEC_N,
  parameter int W = VEC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [W-1:0]         load_data [N],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last,
  output logic                 busy
`ifdef VEC_STREAM_CHECKSUM_EN
  ,
  output logic [W-1:0]         checksum_out,
  output logic                 checksum_valid
`endif
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  vec_stream_state_t state_q, state_d;

  logic [W-1:0]  buf_q [N];
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] idx_inc;
  logic [W-1:0]  data_q, data_d;
  logic          last_q, last_d;

  logic capture;     // vector accepted this cycle
  logic beat;        // one element transferred this cycle
  logic final_beat;  // element N-1 transferred this cycle

  assign capture    = load_valid && (state_q == S_IDLE);
  assign beat       = out_ready && (state_q == S_STREAM);
  assign final_beat = beat && last_q;
  assign idx_inc    = idx_q + 1'b1;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (capture)    state_d = S_STREAM;
      S_STREAM: if (final_beat) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output beat registers. out_data is preloaded from the buffer one beat
  // ahead so the element leaves a flop rather than a wide read mux.
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d  = idx_q;
    data_d = data_q;
    last_d = last_q;
    if (capture) begin
      idx_d  = '0;
      data_d = load_data[0];
      last_d = 1'b0;                 // N >= 2, so index 0 is never last
    end else if (final_beat) begin
      idx_d  = '0;                   // out_data keeps the last element
      last_d = 1'b0;
    end else if (beat) begin
      idx_d  = idx_inc;
      data_d = buf_q[idx_inc];
      last_d = (idx_inc == LAST_IDX);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Vector buffer. Written only on capture, so load_data is ignored while busy.
  // ---------------------------------------------------------------------------
  // NOTE: the buffer is cleared on reset because its post-reset contents are
  // defined behaviour; plain storage arrays usually skip reset to stay RAM-able.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else if (capture) begin
      buf_q <= load_data;
    end
  end

  assign load_ready = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_STREAM);
  assign busy       = (state_q == S_STREAM);
  assign out_data   = data_q;
  assign out_index  = idx_q;
  assign out_last   = last_q;

`ifdef VEC_STREAM_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Running sum of transferred elements; published on the final beat so the
  // result is stable until the next vector completes.
  // ---------------------------------------------------------------------------
  logic [W-1:0] acc_q;
  logic [W-1:0] csum_q;
  logic         csum_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else begin
      csum_valid_q <= final_beat;
      if (capture)   acc_q  <= '0;
      else if (beat) acc_q  <= acc_q + data_q;
      if (final_beat) csum_q <= acc_q + data_q;
    end
  end

  assign checksum_out   = csum_q;
  assign checksum_valid = csum_valid_q;
`endif

endmodule : vector_stream_out

// File: tb/tb_vector_stream_out.sv
// -----------------------------------------------------------------------------
// tb_vector_stream_out
//   Self-checking bench for vector_stream_out. Each vector is modelled as a
//   plain array; the expected beat sequence is element k at index k, with the
//   consumer's ready pattern chosen per test. Checksum ports are checked when
//   VEC_STREAM_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_vector_stream_out;
  import vec_pkg::*;

  localparam int N  = VEC_N;
  localparam int W  = VEC_W;
  localparam int IW = $clog2(N);

  logic          clk;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  load_data [N];
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;
`ifdef VEC_STREAM_CHECKSUM_EN
  logic [W-1:0]  checksum_out;
  logic          checksum_valid;
`endif

  vector_stream_out #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy)
`ifdef VEC_STREAM_CHECKSUM_EN
    ,
    .checksum_out   (checksum_out),
    .checksum_valid (checksum_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] last_sum = '0;   // checksum of the most recently completed vector

  typedef logic [W-1:0] vec_t [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"},  64'(out_valid),  64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_load_ready"}, 64'(load_ready), 64'd1);
    check({tag, "_out_index"},  64'(out_index),  64'd0);
    check({tag, "_out_last"},   64'(out_last),   64'd0);
  endtask

  // One idle cycle: stream quiet, checksum pulse over, result held.
  task automatic idle_cycle(input string tag);
    @(negedge clk);
    check_idle(tag);
`ifdef VEC_STREAM_CHECKSUM_EN
    check({tag, "_csum_valid"}, 64'(checksum_valid), 64'd0);
    check({tag, "_csum_out"},   64'(checksum_out),   64'(last_sum));
`endif
  endtask

  // Present a vector for capture at the next rising edge (called at a negedge).
  task automatic load_vec(input vec_t v);
    check("load_ready_before_load", 64'(load_ready), 64'd1);
    load_data  = v;
    load_valid = 1'b1;
  endtask

  // Consume the captured vector v. mode 0: ready always, 1: ready 1,0,0,..,
  // 2: random ready. hold_load keeps load_valid high with nxt on load_data.
  task automatic drain(input string tag, input vec_t v, input int mode,
                       input bit hold_load, input vec_t nxt);
    int           k   = 0;
    int           cyc = 0;
    bit           rdy;
    logic [W-1:0] sum = '0;
    while (k < N && cyc < N * 40) begin
      @(negedge clk);
      cyc++;
      check({tag, "_valid"},      64'(out_valid),  64'd1);
      check({tag, "_busy"},       64'(busy),       64'd1);
      check({tag, "_load_ready"}, 64'(load_ready), 64'd0);
      check({tag, "_index"},      64'(out_index),  64'(k));
      check({tag, "_data"},       64'(out_data),   64'(v[k]));
      check({tag, "_last"},       64'(out_last),   64'(k == N - 1));
      if (hold_load) begin
        load_valid = 1'b1;
        load_data  = nxt;
      end else begin
        load_valid = 1'b0;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (rdy) begin
        sum = sum + v[k];
        k++;
      end
    end
    check({tag, "_all_beats"}, 64'(k), 64'(N));
    if (mode == 0) check({tag, "_full_rate_cycles"}, 64'(cyc), 64'(N));
    // cycle after the last transfer
    @(negedge clk);
    check_idle({tag, "_after_last"});
    last_sum = sum;
`ifdef VEC_STREAM_CHECKSUM_EN
    check({tag, "_csum_valid"}, 64'(checksum_valid), 64'd1);
    check({tag, "_csum_out"},   64'(checksum_out),   64'(sum));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t va, vb, vc;

  initial begin
    // ---- 1: reset values appear immediately, before any clock edge ----
    rst        = 1'b1;
    load_valid = 1'b0;
    out_ready  = 1'b0;
    for (int i = 0; i < N; i++) load_data[i] = '0;
    #1;
    check_idle("reset");
    check("reset_out_data", 64'(out_data), 64'd0);
`ifdef VEC_STREAM_CHECKSUM_EN
    check("reset_csum_valid", 64'(checksum_valid), 64'd0);
    check("reset_csum_out",   64'(checksum_out),   64'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // out_ready while idle has no effect
    out_ready = 1'b1;
    repeat (3) idle_cycle("idle_ready");

    // ---- 2: c[i] = a[i] + b[i] with a=i, b=16-i, full throughput ----
    for (int i = 0; i < N; i++) va[i] = W'(i) + W'(16 - i);
    load_vec(va);
    drain("t2", va, 0, 1'b0, va);
    idle_cycle("t2_idle");

    // ---- 3: c[i] = 3*i with stalled consumer ----
    for (int i = 0; i < N; i++) va[i] = W'(3 * i);
    load_vec(va);
    drain("t3", va, 1, 1'b0, va);
    idle_cycle("t3_idle");

    // ---- 4: load attempts while busy are ignored; second vector waits ----
    for (int i = 0; i < N; i++) begin
      va[i] = W'($urandom);
      vb[i] = ~va[i];
    end
    load_vec(va);
    drain("t4a", va, 2, 1'b1, vb);
    drain("t4b", vb, 0, 1'b0, vb);
    idle_cycle("t4_idle");

    // ---- 5: reset mid-stream at index 7, then a wrapping checksum ----
    for (int i = 0; i < N; i++) va[i] = W'($urandom);
    load_vec(va);
    out_ready = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    check("t5_first_index", 64'(out_index), 64'd0);
    repeat (7) @(negedge clk);
    check("t5_index_before_rst", 64'(out_index), 64'd7);
    check("t5_data_before_rst",  64'(out_data),  64'(va[7]));
    #2 rst = 1'b1;
    #1;
    check_idle("t5_rst");
    check("t5_rst_out_data", 64'(out_data), 64'd0);
    last_sum = '0;
`ifdef VEC_STREAM_CHECKSUM_EN
    check("t5_rst_csum_out", 64'(checksum_out), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    idle_cycle("t5_after_rst");
    for (int i = 0; i < N; i++) va[i] = 32'hFFFF_FFFF;
    load_vec(va);
    drain("t5", va, 2, 1'b0, va);
    check("t5_wrap_sum", 64'(last_sum), 64'h0000_0000_FFFF_FFF0);
    idle_cycle("t5_idle");

    // ---- 6: back-to-back vectors, load_valid held, one idle cycle between ----
    for (int i = 0; i < N; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
      vc[i] = W'($urandom);
    end
    out_ready = 1'b1;
    load_vec(va);
    drain("t6a", va, 0, 1'b1, vb);
    drain("t6b", vb, 0, 1'b1, vc);
    drain("t6c", vc, 0, 1'b0, vc);
    idle_cycle("t6_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_vector_stream_out
